// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_alu                                                       |
// | Purpose  : Registered WIDTH-bit ALU with valid/ready handshakes on both  |
// |            sides. Adder-based arithmetic, logic ops, 1-bit shifts, an    |
// |            iterative shift-add multiply and an accumulator operand mode. |
// | Ports    : clk, reset        - clock, synchronous active-high reset      |
// |            in_valid/in_ready - operation request handshake               |
// |            x, y, select      - operands and 4-bit opcode                 |
// |            use_acc           - take operand A from the accumulator       |
// |            out_valid/out_ready - result handshake                        |
// |            out, c_out, zero  - result, carry/flag, result-is-zero        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       select,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'hE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  logic [WIDTH-1:0]   operand_a;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_c;
  logic [2*WIDTH-1:0] prod_next;
  logic               mul_last;

  assign operand_a = use_acc ? acc : x;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  // Final multiply step happens when the counter is about to reach zero.
  assign mul_last  = (count <= CNT_W'(1));
  assign prod_next = product + (mplier[0] ? mcand : '0);

  // Single-cycle result; arithmetic is A + B + select[0] with B chosen by select[2:1].
  always_comb begin
    addend = '0;
    case (select[2:1])
      2'b00:   addend = '0;
      2'b01:   addend = y;
      2'b10:   addend = ~y;
      default: addend = '1;
    endcase
    sum     = {1'b0, operand_a} + {1'b0, addend} + {{WIDTH{1'b0}}, select[0]};
    alu_out = sum[WIDTH-1:0];
    alu_c   = sum[WIDTH];
    if (select[3]) begin
      alu_c = 1'b0;
      case (select[2:0])
        3'd0: alu_out = operand_a & y;
        3'd1: alu_out = operand_a | y;
        3'd2: alu_out = operand_a ^ y;
        3'd3: alu_out = ~operand_a;
        3'd4: begin
          alu_out = {operand_a[WIDTH-2:0], 1'b0};
          alu_c   = operand_a[WIDTH-1];
        end
        3'd5: begin
          alu_out = {1'b0, operand_a[WIDTH-1:1]};
          alu_c   = operand_a[0];
        end
        default: alu_out = '0;  // 6 is multiply (handled by MUL), 7 is clear
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (select == OP_MUL) ? MUL : HOLD;
      MUL:     if (mul_last) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      out     <= '0;
      c_out   <= 1'b0;
      zero    <= 1'b0;
      count   <= '0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (select == OP_MUL) begin
              count   <= CNT_W'(WIDTH);
              product <= '0;
              mcand   <= {{WIDTH{1'b0}}, operand_a};
              mplier  <= y;
            end else begin
              out   <= alu_out;
              c_out <= alu_c;
              zero  <= (alu_out == '0);
            end
          end
        end
        MUL: begin
          product <= prod_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          count   <= count - CNT_W'(1);
          if (mul_last) begin
            out   <= prod_next[WIDTH-1:0];
            c_out <= |prod_next[2*WIDTH-1:WIDTH];
            zero  <= (prod_next[WIDTH-1:0] == '0);
          end
        end
        HOLD: begin
          if (out_ready) acc <= out;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_alu                                                    |
// | Purpose  : Self-checking bench for seq_alu (WIDTH=4) with a scoreboard   |
// |            queue of expected results.                                    |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic [3:0] select = '0;
  logic       use_acc = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out;
  logic       c_out;
  logic       zero;

  typedef struct {
    logic [3:0] o;
    logic       c;
    logic       z;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_acc = '0;
  int         n_vec = 0;
  int         n_err = 0;

  seq_alu #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .select(select), .use_acc(use_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .c_out(c_out), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model written from the opcode table with plain integer math.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    exp_t e;
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    r = 0;
    e.c = 1'b0;
    e.lat = 1;
    case (s)
      4'h0: r = ia;
      4'h1: r = ia + 1;
      4'h2: r = ia + ib;
      4'h3: r = ia + ib + 1;
      4'h4: r = ia + (15 - ib);
      4'h5: r = ia + (15 - ib) + 1;
      4'h6: r = ia + 15;
      4'h7: r = ia + 16;
      4'h8: r = ia & ib;
      4'h9: r = ia | ib;
      4'hA: r = ia ^ ib;
      4'hB: r = 15 - ia;
      4'hC: r = ia * 2;
      4'hD: r = ia / 2;
      4'hE: r = ia * ib;
      default: r = 0;
    endcase
    if (s <= 4'h7) e.c = (r > 15);
    else if (s == 4'hC) e.c = (ia >= 8);
    else if (s == 4'hD) e.c = (ia % 2) == 1;
    else if (s == 4'hE) begin
      e.c = (r > 15);
      e.lat = 5;
    end
    e.o = 4'(r % 16);
    e.z = (e.o == 4'd0);
    return e;
  endfunction

  // Drives one operation and returns what the DUT presents when out_valid rises.
  task automatic run_op(input logic [3:0] xi, input logic [3:0] yi, input logic [3:0] si,
                        input logic ua, input logic ord,
                        output logic [3:0] o, output logic c, output logic z, output int lat);
    int guard;
    @(negedge clk);
    x = xi; y = yi; select = si; use_acc = ua; out_ready = ord; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 4'($urandom);
    y = 4'($urandom);
    select = 4'($urandom);
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    o = out; c = c_out; z = zero;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({in_ready, out_valid, out, c_out, zero} !== 8'b1_0_0000_0_0) begin
      n_err++;
      $display("FAIL reset: got rdy=%b vld=%b out=%b c=%b z=%b, want rdy=1 vld=0 out=0000 c=0 z=0",
               in_ready, out_valid, out, c_out, zero);
    end
    reset = 1'b0;
    model_acc = '0;
  endtask

  task automatic test_exhaustive();
    logic [3:0] o; logic c, z; int lat; exp_t ex;
    for (int s = 0; s < 12; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          sb.push_back(model(4'(a), 4'(b), 4'(s)));
          run_op(4'(a), 4'(b), 4'(s), 1'b0, 1'b1, o, c, z, lat);
          ex = sb.pop_front();
          n_vec++;
          if (o !== ex.o || c !== ex.c || z !== ex.z || lat != ex.lat) begin
            n_err++;
            $display("FAIL exhaustive sel=%0h x=%0d y=%0d: got out=%b c=%b z=%b lat=%0d, want out=%b c=%b z=%b lat=%0d",
                     s, a, b, o, c, z, lat, ex.o, ex.c, ex.z, ex.lat);
          end
          model_acc = ex.o;
        end
  endtask

  task automatic test_multiply();
    logic [3:0] xs [3] = '{4'd15, 4'd3, 4'd0};
    logic [3:0] ys [3] = '{4'd15, 4'd5, 4'd9};
    logic [3:0] o; logic c, z; int lat; exp_t ex;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(xs[i], ys[i], 4'hE));
      run_op(xs[i], ys[i], 4'hE, 1'b0, 1'b1, o, c, z, lat);
      ex = sb.pop_front();
      n_vec++;
      if (o !== ex.o || c !== ex.c || z !== ex.z || lat != ex.lat) begin
        n_err++;
        $display("FAIL multiply %0dx%0d: got out=%b c=%b z=%b lat=%0d, want out=%b c=%b z=%b lat=%0d",
                 xs[i], ys[i], o, c, z, lat, ex.o, ex.c, ex.z, ex.lat);
      end
      model_acc = ex.o;
    end
  endtask

  task automatic test_shifts();
    logic [3:0] sels [2] = '{4'hC, 4'hD};
    logic [3:0] want [2] = '{4'b0010, 4'b0100};
    logic [3:0] o; logic c, z; int lat; exp_t ex;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(4'b1001, 4'd0, sels[i]));
      run_op(4'b1001, 4'd0, sels[i], 1'b0, 1'b1, o, c, z, lat);
      ex = sb.pop_front();
      n_vec++;
      if (o !== ex.o || o !== want[i] || c !== 1'b1 || lat != 1) begin
        n_err++;
        $display("FAIL shift sel=%0h: got out=%b c=%b lat=%0d, want out=%b c=1 lat=1",
                 sels[i], o, c, lat, want[i]);
      end
      model_acc = ex.o;
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] o; logic c, z; int lat, hs; exp_t ex;
    sb.push_back(model(4'd7, 4'd9, 4'h2));
    run_op(4'd7, 4'd9, 4'h2, 1'b0, 1'b0, o, c, z, lat);
    ex = sb.pop_front();
    n_vec++;
    if (o !== ex.o || c !== ex.c || z !== ex.z || lat != 1) begin
      n_err++;
      $display("FAIL bp_result: got out=%b c=%b z=%b lat=%0d, want out=%b c=%b z=%b lat=1",
               o, c, z, lat, ex.o, ex.c, ex.z);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      x = 4'($urandom);
      y = 4'($urandom);
      select = 4'($urandom);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== 4'b0000 || c_out !== 1'b1 || zero !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b out=%b c=%b z=%b, want vld=1 rdy=0 out=0000 c=1 z=1",
                 i, out_valid, in_ready, out, c_out, zero);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) hs++;
      @(negedge clk);
    end
    n_vec++;
    if (hs != 1 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got handshakes=%0d rdy=%b, want handshakes=1 rdy=1", hs, in_ready);
    end
    model_acc = ex.o;
  endtask

  task automatic test_acc_chain();
    logic [3:0] sels [6] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'hF, 4'h0};
    logic       uas  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] want [6] = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd0};
    logic [3:0] o, a, xi; logic c, z; int lat; exp_t ex;
    for (int i = 0; i < 6; i++) begin
      xi = (i == 0) ? 4'd6 : 4'd5;
      a = uas[i] ? model_acc : xi;
      sb.push_back(model(a, 4'd3, sels[i]));
      run_op(xi, 4'd3, sels[i], uas[i], 1'b1, o, c, z, lat);
      ex = sb.pop_front();
      n_vec++;
      if (o !== ex.o || o !== want[i] || c !== ex.c || z !== ex.z || lat != 1) begin
        n_err++;
        $display("FAIL acc_chain step %0d: got out=%b c=%b z=%b lat=%0d, want out=%b c=%b z=%b lat=1",
                 i, o, c, z, lat, want[i], ex.c, ex.z);
      end
      model_acc = ex.o;
    end
    use_acc = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t ex;
    int accepts;
    accepts = 0;
    @(negedge clk);
    in_valid = 1'b1; use_acc = 1'b1; select = 4'h1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL b2b unexpected result out=%b", out);
        end else begin
          ex = sb.pop_front();
          if (out !== ex.o || c_out !== ex.c || zero !== ex.z) begin
            n_err++;
            $display("FAIL b2b result: got out=%b c=%b z=%b, want out=%b c=%b z=%b",
                     out, c_out, zero, ex.o, ex.c, ex.z);
          end
          model_acc = ex.o;
        end
      end
      if (in_valid && in_ready) begin
        accepts++;
        sb.push_back(model(model_acc, y, select));
      end
      x = 4'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    use_acc = 1'b0;
    n_vec++;
    if (accepts != 6 || sb.size() != 0) begin
      n_err++;
      $display("FAIL b2b throughput: got accepts=%0d pending=%0d, want accepts=6 pending=0",
               accepts, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [3:0] o; logic c, z; int lat; exp_t ex;
    @(negedge clk);
    x = 4'd15; y = 4'd15; select = 4'hE; use_acc = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_mul: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
    end
    reset = 1'b0;
    model_acc = '0;
    // Accumulator must read back as zero after the aborted multiply.
    sb.push_back(model(model_acc, 4'd0, 4'h0));
    run_op(4'd11, 4'd0, 4'h0, 1'b1, 1'b1, o, c, z, lat);
    ex = sb.pop_front();
    n_vec++;
    if (o !== ex.o || c !== ex.c || z !== ex.z || lat != 1) begin
      n_err++;
      $display("FAIL reset_acc: got out=%b c=%b z=%b lat=%0d, want out=%b c=%b z=%b lat=1",
               o, c, z, lat, ex.o, ex.c, ex.z);
    end
    model_acc = ex.o;
    sb.push_back(model(4'd1, 4'd1, 4'h2));
    run_op(4'd1, 4'd1, 4'h2, 1'b0, 1'b1, o, c, z, lat);
    ex = sb.pop_front();
    n_vec++;
    if (o !== ex.o || o !== 4'b0010 || c !== ex.c || lat != 1) begin
      n_err++;
      $display("FAIL reset_add: got out=%b c=%b lat=%0d, want out=0010 c=%b lat=1", o, c, lat, ex.c);
    end
    model_acc = ex.o;
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_multiply();
    test_shifts();
    test_backpressure();
    test_acc_chain();
    test_back_to_back();
    test_reset_mid_mul();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
